// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, LSB first) fed by a byte FIFO, with a polled STATUS register.
// Latency: start bit appears on txd 2 clk after the TXDATA write edge; STATUS read data is valid 1 clk after d_re.
// Backpressure: none on the bus; a write to a full FIFO is dropped and sets sticky overflow.
// Optional: define UART_TX_PARITY_EN for an even-parity bit after the data bits (STATUS bit 16 reads 1).

// Small synchronous FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [DW-1:0] mem [2 ** AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at 2^AW; count spans 0..2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_mmio #(
  parameter logic [31:0] BASE    = 32'hffff0004,
  parameter int          CLKDIV  = 868,
  parameter int          FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_adr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_dw,
  input  logic        d_re,
  output logic [31:0] d_dr,
  output logic        d_dr_en,
  output logic        txd,
  output logic        tx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [31:0] STATUS_ADR  = BASE + 32'd4;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKDIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA  = PARITY;
  localparam logic   PARITY_FLAG = 1'b1;
`else
  localparam state_t AFTER_DATA  = STOP;
  localparam logic   PARITY_FLAG = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               pop;
  logic               push;
  logic               status_rd;
  logic               ovf_event;
  logic               busy;
  logic               overflow;
  logic [7:0]         fifo_rdata;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [8:0]         count9;
  logic [31:0]        status_word;
  logic               unused_bits;

  // Only byte lane 0 carries console data.
  assign unused_bits = ^{d_we[3:1], d_dw[31:8]};

  assign push        = d_we[0] && (d_adr == BASE);
  assign status_rd   = d_re && (d_adr == STATUS_ADR);
  assign ovf_event   = push && fifo_full && !pop;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign count9      = 9'(fifo_count);
  assign status_word = {15'b0, PARITY_FLAG, overflow, busy, fifo_full, fifo_empty, 3'b0, count9};

  uart_tx_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (d_dw[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  // Next-state: each state lasts CLKDIV clocks; STOP chains straight into START when more data waits.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          par_d   = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shreg_d = {1'b0, shreg_q[7:1]};
          par_d   = par_q ^ shreg_q[0];
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = AFTER_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      PARITY: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          state_d = STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata;
            par_d   = 1'b0;
            baud_d  = BAUD_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered line and busy outputs, one clock behind the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx_busy <= busy;
      case (state_q)
        START:   txd <= 1'b0;
        DATA:    txd <= shreg_q[0];
        PARITY:  txd <= par_q;
        default: txd <= 1'b1;
      endcase
    end
  end

  // STATUS read port and sticky overflow; a same-cycle overflow wins over the read-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_dr     <= '0;
      d_dr_en  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      d_dr_en <= status_rd;
      if (status_rd) d_dr <= status_word;
      if (ovf_event) overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end
endmodule
